apb_sram_slave: RTL and testbench
=================================

// Module: apb_sram_slave
// PURPOSE
//  Parametrised APB3 memory-mapped slave: byte-strobed SRAM with programmable wait states and PSLVERR.
//  Sits behind the APB bridge/decoder beside the existing fixed-width slaves; one PSEL per instance.
//  Adds over earlier slaves: clocked FSM, registered read data, range checking, wait-state insertion, byte writes.
// PARAMETERS
//  ADDR_W       8   PADDR width (byte address)
//  DATA_W       8   PWDATA/PRDATA width; multiple of 8, max 32
//  DEPTH        64  number of DATA_W words implemented
//  WAIT_STATES  0   PREADY-low cycles inserted in access phase (0..15)
// PORTS
//  PCLK     in   1            APB clock, all logic on rising edge
//  PRESET   in   1            synchronous reset, active-high
//  PSEL     in   1            slave select
//  PENABLE  in   1            access-phase indicator
//  PWRITE   in   1            1 = write, 0 = read
//  PADDR    in   ADDR_W       byte address; word index = PADDR[ADDR_W-1:BW], BW = log2(DATA_W/8)
//  PWDATA   in   DATA_W       write data
//  PSTRB    in   DATA_W/8     byte-lane write enables (ignored on reads)
//  PRDATA   out  DATA_W       read data, registered
//  PREADY   out  1            transfer complete
//  PSLVERR  out  1            error response, valid only while PREADY=1
// BEHAVIOUR
//  Reset (PRESET=1 at edge): state IDLE, wait counter 0, PRDATA=0, PREADY=0, PSLVERR=0.
//   Memory array NOT cleared. Reset mid-transfer aborts it; no write committed.
//  FSM states: IDLE, ACCESS.
//   IDLE: PSEL&!PENABLE (setup) -> latch addr/write/strb/data, cnt<=WAIT_STATES, ACCESS.
//     Read setup in range: PRDATA<=mem[index] at this edge. Out of range: PRDATA<=0.
//   IDLE: PSEL&PENABLE (no prior setup) -> protocol error: PREADY=1, PSLVERR=1 that cycle, no write, stay IDLE.
//   ACCESS: cnt!=0 -> PREADY=0, cnt<=cnt-1.
//   ACCESS: cnt==0 -> PREADY=1 (combinational from state/cnt), PSLVERR=err_q.
//     Edge with PSEL&PENABLE: commit write if PWRITE & !err_q, -> IDLE.
//   ACCESS: PSEL=0 at any edge -> abort, no write, -> IDLE.
//  Latency: WAIT_STATES=0 -> zero-wait APB (setup + 1 access cycle); otherwise access phase = WAIT_STATES+1 cycles.
//  Back-to-back: new setup accepted the cycle after PREADY=1; a read immediately after a write to the
//   same word returns the new data (write committed at the edge before the read setup edge).
//  Address error err_q: word index >= DEPTH, or PADDR[BW-1:0]!=0 (misaligned). Error -> no state change
//   to memory, PRDATA=0, PSLVERR=1 with PREADY.
//  Byte writes: lane i updated iff PSTRB[i]; PSTRB=0 write is a legal no-op, PSLVERR=0.
//  PADDR/PWDATA/PSTRB changes during access phase ignored; setup-phase values are used.
//  PRDATA holds last read value until next read setup or reset; PREADY=0 outside ACCESS/error cycle.
// STRUCTURE
//  apb_pkg: state enum {IDLE, ACCESS}, APB_OKAY/APB_ERR localparams, max WAIT_STATES localparam.
//  Sub-module sram_bytewise #(DATA_W,DEPTH): sync write with per-byte enables, sync read port; no reset.
//  Top holds FSM, wait counter, address decode/range check, output registers.
// TESTING
//  Reset: PRESET=1 2 cycles -> PRDATA=0, PREADY=0, PSLVERR=0; memory contents preserved across reset.
//  Zero-wait write 0xA5 to addr 0x04, read back -> PREADY high in first access cycle, PRDATA=0xA5, PSLVERR=0.
//  WAIT_STATES=3 read -> PREADY low exactly 3 access cycles, high on 4th with correct data.
//  DATA_W=32: write 0x11223344, then PSTRB=4'b0010 write 0xFFFFFFFF -> read 0x1122FF44.
//  Out-of-range addr (index=DEPTH) write then read -> PSLVERR=1 both, PRDATA=0, memory unchanged.
//  PSEL dropped mid-wait / PRESET mid-access -> no write committed, FSM IDLE, next transfer completes normally.

Source files
------------

// File: rtl/apb_sram_slave_pkg.sv
// Shared types and constants for the APB SRAM slave.
// Provides the FSM state type, the APB response codes and the
// wait-state counter sizing used by apb_sram_slave.
package apb_sram_slave_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/apb_sram_slave_sram_bytewise.sv
// Single-port-per-direction SRAM with per-byte write enables.
//   clk   : clock, rising edge
//   we    : write enable; lane i written iff wstrb[i]
//   waddr : write word address
//   wstrb : byte-lane enables
//   wdata : write data
//   re    : read enable; rdata updated only when asserted
//   raddr : read word address
//   rdata : registered read data (holds when re=0)
// The array has no reset; contents survive a system reset.
module sram_bytewise #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/apb_sram_slave.sv
// APB3 slave fronting a byte-strobed SRAM.
//   PCLK/PRESET : clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB : APB request (setup values latched)
//   PRDATA  : registered read data, 0 after reset or an erroring read
//   PREADY  : high in the final access cycle or on a setup-less access
//   PSLVERR : high with PREADY for out-of-range/misaligned or protocol errors
module apb_sram_slave
  import apb_sram_slave_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NB    = DATA_W / 8;
  localparam int BW    = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << BW) - 1);
  localparam logic [CNT_W-1:0]  WAIT_LOAD  = CNT_W'(WAIT_STATES);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [IDX_W-1:0]    addr_q;
  logic                wr_q;
  logic                err_q;
  logic [NB-1:0]       strb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_zero_q;

  logic [ADDR_W-1:0]   word_idx;
  logic                addr_err;
  logic                setup;
  logic                mem_we;
  logic                mem_re;
  logic [DATA_W-1:0]   mem_rdata;

  assign word_idx = PADDR >> BW;
  assign addr_err = (32'(word_idx) >= 32'(DEPTH)) || ((PADDR & ALIGN_MASK) != '0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    setup   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    PREADY  = 1'b0;
    PSLVERR = APB_OKAY;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          state_d = ACCESS;
          cnt_d   = WAIT_LOAD;
          mem_re  = !PWRITE && !addr_err;
        end else if (PSEL && PENABLE) begin
          PREADY  = 1'b1;
          PSLVERR = APB_ERR;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          PREADY  = 1'b1;
          PSLVERR = err_q;
        end
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (PENABLE) begin
          mem_we  = wr_q && !err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over any pending memory access at the same edge.
    if (PRESET) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (setup) begin
        addr_q  <= IDX_W'(word_idx);
        wr_q    <= PWRITE;
        err_q   <= addr_err;
        strb_q  <= PSTRB;
        wdata_q <= PWDATA;
        if (!PWRITE) begin
          rd_zero_q <= addr_err;
        end
      end
    end
  end

  sram_bytewise #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk   (PCLK),
    .we    (mem_we),
    .waddr (addr_q),
    .wstrb (strb_q),
    .wdata (wdata_q),
    .re    (mem_re),
    .raddr (IDX_W'(word_idx)),
    .rdata (mem_rdata)
  );

  // SRAM has no reset, so a registered flag forces PRDATA to 0 after
  // reset or an erroring read while the SRAM output register holds.
  assign PRDATA = rd_zero_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_apb_sram_slave.sv
module tb_apb_sram_slave;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        sel_a   = 1'b0;
  logic        sel_b   = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [7:0]  paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic [3:0]  pstrb   = '0;

  logic [7:0]  prdata_a;
  logic        ready_a, slverr_a;
  logic [31:0] prdata_b;
  logic        ready_b, slverr_b;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  // Reference contents: A is 64 bytes, B is 16 words of 4 bytes.
  logic [7:0]  mem_a [64];
  logic [31:0] mem_b [16];

  always #5 clk = ~clk;

  apb_sram_slave #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_STATES(0)
  ) dut_a (
    .PCLK(clk), .PRESET(rst), .PSEL(sel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata[7:0]), .PSTRB(pstrb[0:0]),
    .PRDATA(prdata_a), .PREADY(ready_a), .PSLVERR(slverr_a)
  );

  apb_sram_slave #(
    .ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(3)
  ) dut_b (
    .PCLK(clk), .PRESET(rst), .PSEL(sel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_b), .PREADY(ready_b), .PSLVERR(slverr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input bit b, input logic [7:0] addr);
    int a;
    a = int'(addr);
    if (b) return (a / 4 >= 16) || (a % 4 != 0);
    return a >= 64;
  endfunction

  function automatic logic [31:0] exp_word(input bit b, input logic [7:0] addr);
    int a;
    a = int'(addr);
    if (exp_err(b, addr)) return 32'h0;
    if (b) return mem_b[a / 4];
    return {24'h0, mem_a[a]};
  endfunction

  task automatic model_write(input bit b, input logic [7:0] addr, input logic [31:0] wd,
                             input logic [3:0] st);
    int a;
    a = int'(addr);
    if (!exp_err(b, addr)) begin
      if (b) begin
        for (int i = 0; i < 4; i++) begin
          if (st[i]) mem_b[a / 4][8*i +: 8] = wd[8*i +: 8];
        end
      end else if (st[0]) begin
        mem_a[a] = wd[7:0];
      end
    end
  endtask

  function automatic logic rdy(input bit b);
    return b ? ready_b : ready_a;
  endfunction

  // Setup on one negedge, access from the next; returns once PREADY is
  // seen high (or after 40 low cycles), leaving the bus in access phase.
  task automatic xfer(input bit b, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int waits);
    @(negedge clk);
    sel_a = !b; sel_b = b; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    // Access-phase values must be ignored by the slave.
    paddr = 8'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
    waits = 0;
    #1;
    while (rdy(b) !== 1'b1 && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    rd  = b ? prdata_b : {24'h0, prdata_a};
    err = b ? slverr_b : slverr_a;
  endtask

  task automatic do_op(input bit b, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input string tag);
    logic [31:0] rd, want;
    logic        err;
    int          waits;
    want = exp_word(b, addr);
    xfer(b, wr, addr, wd, st, rd, err, waits);
    chk({tag, "_wait"}, 32'(waits), b ? 32'd3 : 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err(b, addr)));
    if (!wr) chk({tag, "_rdata"}, rd, want);
    if (wr) model_write(b, addr, wd, st);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    sel_a = 1'b0; sel_b = 1'b0; penable = 1'b0;
  endtask

  initial begin
    bit          rb, rw;
    logic [7:0]  ra;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_prdata_a", {24'h0, prdata_a}, 32'h0);
    chk("rst_ready_a", 32'(ready_a), 32'h0);
    chk("rst_slverr_a", 32'(slverr_a), 32'h0);
    chk("rst_prdata_b", prdata_b, 32'h0);
    chk("rst_ready_b", 32'(ready_b), 32'h0);
    chk("rst_slverr_b", 32'(slverr_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill both memories so every later read has a known reference
    for (int i = 0; i < 64; i++) do_op(1'b0, 1'b1, 8'(i), $urandom, 4'hF, "init_a");
    for (int i = 0; i < 16; i++) do_op(1'b1, 1'b1, 8'(i * 4), $urandom, 4'hF, "init_b");

    // Zero-wait write then back-to-back read
    do_op(1'b0, 1'b1, 8'h04, 32'h000000A5, 4'h1, "a_wr04");
    do_op(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, "a_rd04");

    // Wait-stated byte-lane writes and read-after-write
    do_op(1'b1, 1'b1, 8'h08, 32'h11223344, 4'hF, "b_full");
    do_op(1'b1, 1'b1, 8'h08, 32'hFFFFFFFF, 4'b0010, "b_lane1");
    do_op(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, "b_rd08");
    chk("b_rd08_model", mem_b[2], 32'h1122FF44);
    do_op(1'b1, 1'b1, 8'h0C, 32'h0BADF00D, 4'h0, "b_nostrb");
    do_op(1'b1, 1'b0, 8'h0C, 32'h0, 4'h0, "b_rd0c");

    // Out-of-range and misaligned accesses
    do_op(1'b0, 1'b1, 8'h40, 32'h5A, 4'h1, "a_oor_wr");
    do_op(1'b0, 1'b0, 8'h40, 32'h0, 4'h0, "a_oor_rd");
    do_op(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, "a_rd00");
    do_op(1'b1, 1'b1, 8'h40, 32'hCAFEBABE, 4'hF, "b_oor_wr");
    do_op(1'b1, 1'b0, 8'h40, 32'h0, 4'h0, "b_oor_rd");
    do_op(1'b1, 1'b1, 8'h05, 32'hCAFEBABE, 4'hF, "b_mis_wr");
    do_op(1'b1, 1'b0, 8'h05, 32'h0, 4'h0, "b_mis_rd");
    do_op(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, "b_rd00");
    do_op(1'b1, 1'b0, 8'h04, 32'h0, 4'h0, "b_rd04");

    // PSEL dropped during wait states
    bus_idle();
    @(negedge clk);
    sel_b = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h0C; pwdata = ~mem_b[3]; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk("drop_wait1", 32'(ready_b), 32'h0);
    @(negedge clk);
    #1;
    chk("drop_wait2", 32'(ready_b), 32'h0);
    sel_b = 1'b0; penable = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_idle", 32'(ready_b), 32'h0);
    do_op(1'b1, 1'b0, 8'h0C, 32'h0, 4'h0, "drop_rd");

    // Reset in the access cycle of a write
    bus_idle();
    @(negedge clk);
    sel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h10; pwdata = {24'h0, ~mem_a[16]}; pstrb = 4'h1;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sel_a = 1'b0; penable = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_a), 32'h0);
    chk("midrst_prdata", {24'h0, prdata_a}, 32'h0);
    do_op(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, "midrst_rd");

    // Full reset preserves memory contents
    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst2_prdata_a", {24'h0, prdata_a}, 32'h0);
    chk("rst2_prdata_b", prdata_b, 32'h0);
    rst = 1'b0;
    do_op(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, "keep_a04");
    do_op(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, "keep_b08");

    // Access phase without setup
    bus_idle();
    @(negedge clk);
    sel_a = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 8'h20; pwdata = {24'h0, ~mem_a[32]}; pstrb = 4'h1;
    #1;
    chk("proto_ready", 32'(ready_a), 32'h1);
    chk("proto_slverr", 32'(slverr_a), 32'h1);
    @(negedge clk);
    sel_a = 1'b0; penable = 1'b0;
    #1;
    chk("proto_idle", 32'(ready_a), 32'h0);
    do_op(1'b0, 1'b0, 8'h20, 32'h0, 4'h0, "proto_rd");

    // Randomised traffic against the reference contents
    for (int n = 0; n < 80; n++) begin
      rb = 1'($urandom);
      rw = 1'($urandom);
      ra = rb ? 8'($urandom_range(0, 71)) : 8'($urandom_range(0, 79));
      if (rb && ($urandom % 4 != 0)) ra = ra & 8'hFC;
      do_op(rb, rw, ra, $urandom, 4'($urandom), $sformatf("rnd%0d", n));
      if ($urandom % 3 == 0) bus_idle();
    end

    bus_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
